// File: rtl/control_types_pkg.sv
// Shared CPU control encodings; mem_op_t selects load/store size and signedness.
package control_types_pkg;

    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_op_t;

endpackage

// File: rtl/mmio_test_pkg.sv
// Register map, FSM states and store-lane helper for the MMIO test-harness responder.
package mmio_test_pkg;

    import control_types_pkg::*;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8000_0000;

    localparam logic [2:0] TOHOST_OFF  = 3'd0;
    localparam logic [2:0] CONSOLE_OFF = 3'd1;
    localparam logic [2:0] CYCLE_OFF   = 3'd2;
    localparam logic [2:0] STATUS_OFF  = 3'd3;
    localparam logic [2:0] SCRATCH_OFF = 3'd4;

    typedef enum logic [1:0] {
        RUN,
        PASS,
        FAIL,
        TIMEOUT
    } tohost_state_t;

    // Byte-lane mask of a store before it is moved to its address offset.
    function automatic logic [31:0] store_mask(input mem_op_t op);
        case (op)
            MEM_B, MEM_BU: store_mask = 32'h0000_00FF;
            MEM_H, MEM_HU: store_mask = 32'h0000_FFFF;
            default:       store_mask = 32'hFFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/mmio_load_align.sv
// Load alignment for bus responders: shift by byte offset, truncate to size, sign/zero extend.
module mmio_load_align
    import control_types_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  offset_i,
    input  mem_op_t     mem_ctrl_i,
    output logic [31:0] data_o
);

    logic [31:0] shifted;

    always_comb begin
        shifted = word_i >> {offset_i, 3'b000};
        case (mem_ctrl_i)
            MEM_B:   data_o = {{24{shifted[7]}}, shifted[7:0]};
            MEM_BU:  data_o = {24'b0, shifted[7:0]};
            MEM_H:   data_o = {{16{shifted[15]}}, shifted[15:0]};
            MEM_HU:  data_o = {16'b0, shifted[15:0]};
            default: data_o = shifted;
        endcase
    end

endmodule

// File: rtl/mmio_test_device.sv
// Test-harness MMIO responder: TOHOST completion FSM, byte console, cycle counter,
// scratch register and RUN-state watchdog in a 32-byte window at BASE_ADDR.
module mmio_test_device
    import control_types_pkg::*;
    import mmio_test_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = DEFAULT_BASE_ADDR,
    parameter int unsigned TIMEOUT_CYCLES = 10000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        wr_en,
    input  mem_op_t     mem_ctrl,
    input  logic [31:0] addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        done,
    output logic        pass,
    output logic [30:0] fail_code,
    output logic        timeout,
    output logic        char_valid,
    output logic [7:0]  char_data
);

    localparam logic [31:0] WDOG_LIMIT = 32'(TIMEOUT_CYCLES);

    tohost_state_t state_q, state_d;
    logic [31:0]   cycle_q;
    logic [31:0]   wdog_q, wdog_d;
    logic [31:0]   scratch_q, scratch_d;
    logic [30:0]   fail_code_q, fail_code_d;
    logic          char_valid_q;
    logic [7:0]    char_data_q;

    logic          sel;
    logic [2:0]    reg_idx;
    logic          wr_sel, tohost_wr, console_wr, scratch_wr;
    logic [4:0]    lane_shift;
    logic [31:0]   lane_mask, lane_data;
    logic [31:0]   read_word, aligned;

    assign sel        = (addr[31:5] == BASE_ADDR[31:5]);
    assign reg_idx    = addr[4:2];
    assign wr_sel     = wr_en && sel;
    assign tohost_wr  = wr_sel && (reg_idx == TOHOST_OFF);
    assign console_wr = wr_sel && (reg_idx == CONSOLE_OFF);
    assign scratch_wr = wr_sel && (reg_idx == SCRATCH_OFF);

    always_comb begin
        case (reg_idx)
            CYCLE_OFF:   read_word = cycle_q;
            STATUS_OFF:  read_word = {29'b0, timeout, (state_q == FAIL), pass};
            SCRATCH_OFF: read_word = scratch_q;
            default:     read_word = '0;
        endcase
    end

    mmio_load_align u_load_align (
        .word_i     (read_word),
        .offset_i   (addr[1:0]),
        .mem_ctrl_i (mem_ctrl),
        .data_o     (aligned)
    );

    assign data_out = sel ? aligned : '0;

    // Scratch merge: only the lanes covered by the access are replaced.
    assign lane_shift = {addr[1:0], 3'b000};
    assign lane_mask  = store_mask(mem_ctrl) << lane_shift;
    assign lane_data  = data_in << lane_shift;
    assign scratch_d  = scratch_wr ? ((scratch_q & ~lane_mask) | (lane_data & lane_mask))
                                   : scratch_q;

    always_comb begin
        // NOTE: every output of this block is defaulted first so no path can infer a latch.
        state_d     = state_q;
        fail_code_d = fail_code_q;
        wdog_d      = wdog_q;
        if (state_q == RUN) begin
            wdog_d = wdog_q + 32'd1;
            if (tohost_wr && data_in == 32'd1) begin
                state_d = PASS;
            end else if (tohost_wr && data_in[0]) begin
                state_d     = FAIL;
                fail_code_d = data_in[31:1];
            end else if (wdog_d == WDOG_LIMIT) begin
                state_d = TIMEOUT;
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments and cleared by the async reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= RUN;
            cycle_q      <= '0;
            wdog_q       <= '0;
            scratch_q    <= '0;
            fail_code_q  <= '0;
            char_valid_q <= 1'b0;
            char_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            cycle_q      <= cycle_q + 32'd1;
            wdog_q       <= wdog_d;
            scratch_q    <= scratch_d;
            fail_code_q  <= fail_code_d;
            char_valid_q <= console_wr;
            if (console_wr) begin
                char_data_q <= data_in[7:0];
            end
        end
    end

    assign done       = (state_q != RUN);
    assign pass       = (state_q == PASS);
    assign timeout    = (state_q == TIMEOUT);
    assign fail_code  = fail_code_q;
    assign char_valid = char_valid_q;
    assign char_data  = char_data_q;

endmodule

// File: tb/tb_mmio_test_device.sv
// Self-checking bench for mmio_test_device: directed scenarios plus randomized traffic
// compared against a byte-level behavioural model of the register window.
`timescale 1ns/1ps
module tb_mmio_test_device;

    import control_types_pkg::*;

    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam int          TMO  = 20;

    logic        clk = 1'b0;
    logic        resetn;
    logic        wr_en;
    mem_op_t     mem_ctrl;
    logic [31:0] addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        done, pass, timeout, char_valid;
    logic [30:0] fail_code;
    logic [7:0]  char_data;

    int compared   = 0;
    int mismatched = 0;

    // Behavioural model state
    int unsigned m_cycle;
    logic [7:0]  m_scratch [4];
    logic        m_done, m_pass, m_timeout, m_char_valid;
    logic [30:0] m_fail_code;
    logic [7:0]  m_char_data;

    always #5 clk = ~clk;

    mmio_test_device #(
        .BASE_ADDR      (BASE),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .wr_en      (wr_en),
        .mem_ctrl   (mem_ctrl),
        .addr       (addr),
        .data_in    (data_in),
        .data_out   (data_out),
        .done       (done),
        .pass       (pass),
        .fail_code  (fail_code),
        .timeout    (timeout),
        .char_valid (char_valid),
        .char_data  (char_data)
    );

    function automatic int size_of(mem_op_t op);
        case (op)
            MEM_B, MEM_BU: return 1;
            MEM_H, MEM_HU: return 2;
            default:       return 4;
        endcase
    endfunction

    function automatic logic [31:0] model_word(logic [2:0] idx);
        case (idx)
            3'd2:    return m_cycle;
            3'd3:    return {29'b0, m_timeout, (m_done && !m_pass && !m_timeout), m_pass};
            3'd4:    return {m_scratch[3], m_scratch[2], m_scratch[1], m_scratch[0]};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] model_read(logic [31:0] a, mem_op_t op);
        logic [31:0] w, v;
        int off, n;
        if (a[31:5] != BASE[31:5]) return 32'h0;
        w = model_word(a[4:2]);
        off = int'(a[1:0]);
        n = size_of(op);
        v = 32'h0;
        for (int i = 0; i < n; i++)
            if (off + i < 4) v[8*i +: 8] = w[8*(off+i) +: 8];
        if ((op == MEM_B || op == MEM_H) && v[8*n-1])
            for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    task automatic model_reset();
        m_cycle = 0;
        for (int i = 0; i < 4; i++) m_scratch[i] = 8'h00;
        m_done = 0; m_pass = 0; m_timeout = 0; m_char_valid = 0;
        m_fail_code = '0; m_char_data = 8'h00;
    endtask

    // Applies the effect of the coming rising edge, given the inputs now being driven.
    task automatic model_edge();
        bit s;
        logic [2:0] idx;
        int off, n;
        s   = wr_en && (addr[31:5] == BASE[31:5]);
        idx = addr[4:2];
        off = int'(addr[1:0]);
        n   = size_of(mem_ctrl);
        m_cycle++;
        m_char_valid = s && idx == 3'd1;
        if (m_char_valid) m_char_data = data_in[7:0];
        if (s && idx == 3'd4)
            for (int i = 0; i < n; i++)
                if (off + i < 4) m_scratch[off+i] = data_in[8*i +: 8];
        if (!m_done) begin
            if (s && idx == 3'd0 && data_in == 32'd1) begin
                m_done = 1; m_pass = 1;
            end else if (s && idx == 3'd0 && data_in[0]) begin
                m_done = 1; m_fail_code = data_in[31:1];
            end else if (m_cycle == TMO) begin
                m_done = 1; m_timeout = 1;
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input mem_op_t op);
        wr_en = w; addr = a; data_in = d; mem_ctrl = op;
        #1;
    endtask

    task automatic do_reset();
        wr_en = 0; addr = 32'h0; data_in = 32'h0; mem_ctrl = MEM_W;
        resetn = 0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1;
        model_reset();
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        compared++; if ({done, pass, timeout, char_valid} !== 4'b0) begin
            mismatched++; $display("FAIL reset_flags: got %b want 0000", {done, pass, timeout, char_valid}); end
        compared++; if (fail_code !== 31'h0 || char_data !== 8'h00) begin
            mismatched++; $display("FAIL reset_codes: got %h/%h want 0/0", fail_code, char_data); end
        drive(0, BASE + 32'h10, 0, MEM_W);
        compared++; if (data_out !== 32'h0) begin
            mismatched++; $display("FAIL reset_scratch: got %h want 0", data_out); end
        for (int n = 0; n < 3; n++) begin
            drive(0, BASE + 32'h08, 0, MEM_W);
            compared++; if (data_out !== 32'(n)) begin
                mismatched++; $display("FAIL cycle_count: got %0d want %0d", data_out, n); end
            step();
        end
    endtask

    task automatic test_pass();
        do_reset();
        drive(1, BASE, 32'h1, MEM_W);
        step();
        drive(0, BASE + 32'h0C, 0, MEM_W);
        compared++; if ({done, pass, timeout} !== 3'b110 || fail_code !== 31'h0) begin
            mismatched++; $display("FAIL pass_state: got d/p/t=%b code=%h want 110 code=0", {done, pass, timeout}, fail_code); end
        compared++; if (data_out !== 32'h1) begin
            mismatched++; $display("FAIL pass_status: got %h want 00000001", data_out); end
    endtask

    task automatic test_fail();
        do_reset();
        drive(1, BASE, 32'h7, MEM_W);
        step();
        drive(1, BASE, 32'h1, MEM_W);
        step();
        drive(0, BASE + 32'h0C, 0, MEM_W);
        compared++; if ({done, pass, timeout} !== 3'b100 || fail_code !== 31'd3) begin
            mismatched++; $display("FAIL fail_state: got d/p/t=%b code=%0d want 100 code=3", {done, pass, timeout}, fail_code); end
        compared++; if (data_out !== 32'h2) begin
            mismatched++; $display("FAIL fail_status: got %h want 00000002", data_out); end
    endtask

    task automatic test_console();
        do_reset();
        drive(1, BASE + 32'h04, 32'h48, MEM_W);
        step();
        compared++; if (char_valid !== 1'b1 || char_data !== 8'h48) begin
            mismatched++; $display("FAIL console_first: got v=%b d=%h want v=1 d=48", char_valid, char_data); end
        drive(1, BASE + 32'h04, 32'h69, MEM_B);
        step();
        compared++; if (char_valid !== 1'b1 || char_data !== 8'h69) begin
            mismatched++; $display("FAIL console_second: got v=%b d=%h want v=1 d=69", char_valid, char_data); end
        drive(0, BASE + 32'h04, 32'h0, MEM_W);
        step();
        compared++; if (char_valid !== 1'b0 || char_data !== 8'h69) begin
            mismatched++; $display("FAIL console_idle: got v=%b d=%h want v=0 d=69", char_valid, char_data); end
    endtask

    task automatic test_scratch();
        do_reset();
        drive(1, BASE + 32'h10, 32'h1122_3344, MEM_W);
        step();
        drive(1, BASE + 32'h12, 32'h0000_00AA, MEM_B);
        step();
        drive(0, BASE + 32'h10, 0, MEM_W);
        compared++; if (data_out !== 32'h11AA_3344) begin
            mismatched++; $display("FAIL scratch_word: got %h want 11aa3344", data_out); end
        drive(0, BASE + 32'h12, 0, MEM_B);
        compared++; if (data_out !== 32'hFFFF_FFAA) begin
            mismatched++; $display("FAIL scratch_lb: got %h want ffffffaa", data_out); end
        drive(0, BASE + 32'h10, 0, MEM_HU);
        compared++; if (data_out !== 32'h0000_3344) begin
            mismatched++; $display("FAIL scratch_lhu: got %h want 00003344", data_out); end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 0; i < TMO - 1; i++) step();
        compared++; if (timeout !== 1'b0 || done !== 1'b0) begin
            mismatched++; $display("FAIL timeout_early: got t=%b d=%b want 0/0", timeout, done); end
        step();
        compared++; if ({done, pass, timeout} !== 3'b101) begin
            mismatched++; $display("FAIL timeout_fire: got d/p/t=%b want 101", {done, pass, timeout}); end
        drive(1, BASE, 32'h1, MEM_W);
        step();
        compared++; if ({done, pass, timeout} !== 3'b101) begin
            mismatched++; $display("FAIL timeout_terminal: got d/p/t=%b want 101", {done, pass, timeout}); end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(1, BASE + 32'h10, 32'hDEAD_BEEF, MEM_W);
        step();
        drive(1, BASE, 32'h5, MEM_W);
        step();
        drive(1, BASE + 32'h04, 32'h41, MEM_W);
        step();
        compared++; if (char_valid !== 1'b1 || fail_code !== 31'd2 || done !== 1'b1) begin
            mismatched++; $display("FAIL pre_reset: got v=%b code=%0d d=%b want 1/2/1", char_valid, fail_code, done); end
        resetn = 0;
        #1;
        compared++; if ({done, pass, timeout, char_valid} !== 4'b0 || fail_code !== 31'h0 || char_data !== 8'h0) begin
            mismatched++; $display("FAIL async_reset: got flags=%b code=%h char=%h want 0", {done, pass, timeout, char_valid}, fail_code, char_data); end
        drive(0, BASE + 32'h10, 0, MEM_W);
        compared++; if (data_out !== 32'h0) begin
            mismatched++; $display("FAIL async_reset_scratch: got %h want 0", data_out); end
        @(negedge clk);
        resetn = 1;
        model_reset();
        #1;
    endtask

    task automatic test_unselected();
        do_reset();
        drive(1, BASE + 32'h20, 32'h1, MEM_W);
        step();
        drive(1, 32'h0000_0100, 32'h1, MEM_W);
        step();
        drive(1, BASE + 32'h30, 32'hCAFE_F00D, MEM_W);
        step();
        drive(1, BASE + 32'h24, 32'h41, MEM_W);
        step();
        compared++; if (done !== 1'b0 || char_valid !== 1'b0) begin
            mismatched++; $display("FAIL unsel_state: got d=%b v=%b want 0/0", done, char_valid); end
        drive(0, BASE + 32'h28, 0, MEM_W);
        compared++; if (data_out !== 32'h0) begin
            mismatched++; $display("FAIL unsel_read_hi: got %h want 0", data_out); end
        drive(0, 32'h0000_0100, 0, MEM_W);
        compared++; if (data_out !== 32'h0) begin
            mismatched++; $display("FAIL unsel_read_lo: got %h want 0", data_out); end
        drive(0, BASE + 32'h10, 0, MEM_W);
        compared++; if (data_out !== 32'h0) begin
            mismatched++; $display("FAIL unsel_scratch: got %h want 0", data_out); end
    endtask

    task automatic test_random();
        mem_op_t ops [5];
        logic [31:0] a, d, exp;
        ops[0] = MEM_B; ops[1] = MEM_H; ops[2] = MEM_W; ops[3] = MEM_BU; ops[4] = MEM_HU;
        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int c = 0; c < 60; c++) begin
                if ($urandom_range(0, 9) != 0)
                    a = BASE + {27'b0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
                else
                    a = $urandom;
                d = $urandom;
                if (a[4:2] == 3'd0) begin
                    if ($urandom_range(0, 15) == 0) d = 32'h1;
                    else if ($urandom_range(0, 7) != 0) d[0] = 1'b0;
                end
                drive(1'($urandom_range(0, 1)), a, d, ops[$urandom_range(0, 4)]);
                exp = model_read(addr, mem_ctrl);
                compared++; if (data_out !== exp) begin
                    mismatched++; $display("FAIL rand_load a=%h op=%0d: got %h want %h", addr, mem_ctrl, data_out, exp); end
                step();
                compared++; if ({done, pass, timeout} !== {m_done, m_pass, m_timeout}) begin
                    mismatched++; $display("FAIL rand_state: got d/p/t=%b want %b", {done, pass, timeout}, {m_done, m_pass, m_timeout}); end
                compared++; if (fail_code !== m_fail_code) begin
                    mismatched++; $display("FAIL rand_fail_code: got %h want %h", fail_code, m_fail_code); end
                compared++; if (char_valid !== m_char_valid || char_data !== m_char_data) begin
                    mismatched++; $display("FAIL rand_console: got v=%b d=%h want v=%b d=%h", char_valid, char_data, m_char_valid, m_char_data); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_fail();
        test_console();
        test_scratch();
        test_timeout();
        test_async_reset();
        test_unselected();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_time_limit: simulation still running, want finished");
        $fatal(1);
    end

endmodule
